// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, talks to variable-latency
// instruction memory, holds a word across stalls, applies redirects.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        StallF,
  input  logic        PCSrcD,
  input  logic        JumpD,
  input  logic [31:0] PCBranchD,
  input  logic [31:0] PCJumpD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PCF,
  output logic [31:0] InstrF,
  output logic [31:0] PCPlus4F,
  output logic        FetchBusyF,
  output logic        FlushD
);

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_HOLD = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] buf_q, buf_n;
  logic [31:0] redir_pc, redir_n;
  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_inc;

  assign redirect = JumpD | PCSrcD;
  assign target   = JumpD ? {PCJumpD[31:2], 2'b00}
                          : {PCBranchD[31:2], 2'b00};
  assign pc_inc   = pc + 32'd4;

  assign PCF       = pc;
  assign PCPlus4F  = pc_inc;
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_WAIT;
      pc       <= RESET_PC;
      buf_q    <= 32'h0;
      redir_pc <= 32'h0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      buf_q    <= buf_n;
      redir_pc <= redir_n;
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    buf_n      = buf_q;
    redir_n    = redir_pc;
    imem_req   = 1'b0;
    InstrF     = 32'h0;
    FetchBusyF = 1'b0;
    FlushD     = redirect;
    unique case (state)
      S_WAIT: begin
        imem_req   = 1'b1;
        FetchBusyF = !imem_ready;
        if (imem_ready) begin
          InstrF = imem_rdata;
          if (redirect) begin
            pc_n = target;
          end else if (StallF) begin
            buf_n   = imem_rdata;
            state_n = S_HOLD;
          end else begin
            pc_n = pc_inc;
          end
        end else if (redirect) begin
          redir_n = target;
          state_n = S_DROP;
        end
      end
      S_HOLD: begin
        InstrF = buf_q;
        if (redirect) begin
          pc_n    = target;
          state_n = S_WAIT;
        end else if (!StallF) begin
          pc_n    = pc_inc;
          state_n = S_WAIT;
        end
      end
      S_DROP: begin
        imem_req   = 1'b1;
        FetchBusyF = 1'b1;
        if (redirect) redir_n = target;
        if (imem_ready) begin
          // a redirect arriving with the stale response wins
          pc_n    = redirect ? target : redir_pc;
          state_n = S_WAIT;
        end
      end
      default: state_n = S_WAIT;
    endcase
    if (!rst_n) begin
      imem_req   = 1'b0;
      InstrF     = 32'h0;
      FetchBusyF = 1'b0;
      FlushD     = 1'b0;
    end
  end

endmodule
